high_low_cpu_core: RTL and testbench



---
 rtl/high_low_cpu_core_pkg.sv | 59 +++++
 rtl/high_low_cpu_core_if.sv | 11 +
 rtl/high_low_cpu_core_alu.sv | 26 ++
 rtl/high_low_cpu_core.sv | 123 ++++++++++++
 tb/tb_high_low_cpu_core.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/high_low_cpu_core_pkg.sv
// Shared types for the high/low security CPU: instruction word, labeled
// values, control-flow context state and label helpers.
package high_low_cpu_core_pkg;

    typedef enum logic [2:0] {
        OP_COPY      = 3'd0,
        OP_NOT       = 3'd1,
        OP_AND       = 3'd2,
        OP_OR        = 3'd3,
        OP_CLASSIFY  = 3'd4,
        OP_LABEL_OF  = 3'd5,
        OP_SKIP_NEXT = 3'd6,
        OP_ILLEGAL   = 3'd7
    } opcode_t;

    // ZERO and INPUT_* are read-only sources; everything from OUTPUT_HIGH up is stored.
    typedef enum logic [2:0] {
        R_ZERO        = 3'd0,
        R_INPUT_HIGH  = 3'd1,
        R_INPUT_LOW   = 3'd2,
        R_OUTPUT_HIGH = 3'd3,
        R_OUTPUT_LOW  = 3'd4,
        R_REG_A       = 3'd5,
        R_REG_B       = 3'd6,
        R_REG_C       = 3'd7
    } reg_t;

    typedef struct packed {
        opcode_t opcode;
        reg_t    src1;
        reg_t    src2;
        reg_t    dst;
    } instr_t;

    typedef struct packed {
        logic value;
        logic label;
    } value_label_t;

    // Encoding is {skip, ctx}.
    typedef enum logic [1:0] {
        RUN         = 2'b00,
        SHADOW_EXEC = 2'b01,
        SKIP_L      = 2'b10,
        SHADOW_SKIP = 2'b11
    } ctx_state_t;

    localparam logic LABEL_LOW  = 1'b0;
    localparam logic LABEL_HIGH = 1'b1;

    function automatic logic join_label(input logic a, input logic b);
        return a | b;
    endfunction

    function automatic logic is_writable(input reg_t r);
        return r >= R_OUTPUT_HIGH;
    endfunction

endpackage

// File: rtl/high_low_cpu_core_if.sv
// Instruction stream handshake between the instruction source and the core.
interface high_low_cpu_core_if;
    import high_low_cpu_core_pkg::*;

    logic   instr_valid;
    instr_t instr;
    logic   instr_ready;

    modport master (output instr_valid, output instr, input  instr_ready);
    modport slave  (input  instr_valid, input  instr, output instr_ready);
endinterface

// File: rtl/high_low_cpu_core_alu.sv
// Combinational labeled ALU: computes value and security label of a result.
module hl_alu
    import high_low_cpu_core_pkg::*;
(
    input  opcode_t      opcode,
    input  value_label_t op1,
    input  value_label_t op2,
    output value_label_t result
);

    // Result per opcode; SKIP_NEXT and the illegal opcode produce no meaningful result.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        result = '{value: 1'b0, label: LABEL_LOW};
        case (opcode)
            OP_COPY:     result = op1;
            OP_NOT:      result = '{value: ~op1.value, label: op1.label};
            OP_AND:      result = '{value: op1.value & op2.value, label: join_label(op1.label, op2.label)};
            OP_OR:       result = '{value: op1.value | op2.value, label: join_label(op1.label, op2.label)};
            OP_CLASSIFY: result = '{value: op1.value, label: LABEL_HIGH};
            OP_LABEL_OF: result = '{value: op1.label, label: LABEL_LOW};
            default:     result = '{value: 1'b0, label: LABEL_LOW};
        endcase
    end

endmodule

// File: rtl/high_low_cpu_core.sv
// Execution core: labeled register file, skip/shadow control state,
// low-output write guard and retired-beat counter.
module high_low_cpu_core
    import high_low_cpu_core_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    high_low_cpu_core_if.slave   bus,
    input  logic                 in_high,
    input  logic                 in_low,
    output logic                 out_high,
    output logic                 out_low,
    output logic                 viol,
    output logic                 illegal,
    output logic [CNT_W-1:0]     retired
);

    value_label_t rf [3:7];
    ctx_state_t   state, next_state;
    value_label_t op1, op2, alu_res, guarded;
    logic         accept, wr_en, viol_d, illegal_d;
    value_label_t wr_data;
    instr_t       ins;

    assign bus.instr_ready = rst_n;
    assign accept          = bus.instr_valid & bus.instr_ready;
    assign ins             = bus.instr;
    assign out_high        = rf[R_OUTPUT_HIGH].value;
    assign out_low         = rf[R_OUTPUT_LOW].value;

    function automatic value_label_t read_operand(input reg_t r);
        case (r)
            R_ZERO:       return '{value: 1'b0,    label: LABEL_LOW};
            R_INPUT_HIGH: return '{value: in_high, label: LABEL_HIGH};
            R_INPUT_LOW:  return '{value: in_low,  label: LABEL_LOW};
            default:      return rf[r];
        endcase
    endfunction

    // Operand fetch for the beat being accepted.
    always_comb begin
        op1 = read_operand(ins.src1);
        op2 = read_operand(ins.src2);
    end

    hl_alu u_alu (
        .opcode (ins.opcode),
        .op1    (op1),
        .op2    (op2),
        .result (alu_res)
    );

    // Result label raised to the current context (high inside SHADOW_EXEC).
    assign guarded = '{value: alu_res.value, label: join_label(alu_res.label, state[0])};

    // Next control state, register write and flag pulses for an accepted beat.
    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        wr_data    = guarded;
        viol_d     = 1'b0;
        illegal_d  = 1'b0;
        if (accept) begin
            next_state = RUN;
            case (state)
                SKIP_L: ;
                SHADOW_SKIP: begin
                    // Mirror the label effect the executed path would have had.
                    if (ins.opcode != OP_SKIP_NEXT && ins.opcode != OP_ILLEGAL &&
                        is_writable(ins.dst)) begin
                        if (ins.dst == R_OUTPUT_LOW) begin
                            viol_d = 1'b1;
                        end else begin
                            wr_en   = 1'b1;
                            wr_data = '{value: rf[ins.dst].value, label: LABEL_HIGH};
                        end
                    end
                end
                default: begin
                    if (ins.opcode == OP_ILLEGAL) begin
                        illegal_d = 1'b1;
                    end else if (ins.opcode == OP_SKIP_NEXT) begin
                        next_state = ctx_state_t'({op1.value, join_label(op1.label, state[0])});
                    end else if (is_writable(ins.dst)) begin
                        if (ins.dst == R_OUTPUT_LOW && guarded.label == LABEL_HIGH) begin
                            viol_d = 1'b1;
                        end else begin
                            wr_en = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // State, register file, flags and counter update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            viol    <= 1'b0;
            illegal <= 1'b0;
            retired <= '0;
            // NOTE: the register file is tiny and its reset value is architectural, so it is reset.
            for (int i = 3; i <= 7; i++) begin
                rf[i] <= '{value: 1'b0, label: LABEL_LOW};
            end
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state   <= next_state;
            viol    <= viol_d;
            illegal <= illegal_d;
            if (accept) begin
                retired <= retired + 1'b1;
            end
            if (wr_en) begin
                rf[ins.dst] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_high_low_cpu_core.sv
// Directed self-checking bench for high_low_cpu_core: a vector table of
// single beats plus hand-written skip/shadow/reset sequences.
module tb_high_low_cpu_core;
    import high_low_cpu_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_high, in_low;
    logic        out_high, out_low, viol, illegal;
    logic [15:0] retired;
    int          checks = 0;
    int          failures = 0;
    int          exp_ret = 0;

    high_low_cpu_core_if bus ();

    high_low_cpu_core #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .in_high  (in_high),
        .in_low   (in_low),
        .out_high (out_high),
        .out_low  (out_low),
        .viol     (viol),
        .illegal  (illegal),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        opcode_t op;
        reg_t    s1;
        reg_t    s2;
        reg_t    d;
        logic    ih;
        logic    il;
        logic    oh;
        logic    ol;
        logic    v;
        logic    ill;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic oh, input logic ol,
                              input logic v, input logic ill);
        check({tag, " out_high"}, {31'd0, out_high}, {31'd0, oh});
        check({tag, " out_low"},  {31'd0, out_low},  {31'd0, ol});
        check({tag, " viol"},     {31'd0, viol},     {31'd0, v});
        check({tag, " illegal"},  {31'd0, illegal},  {31'd0, ill});
        check({tag, " retired"},  {16'd0, retired},  {16'd0, exp_ret[15:0]});
    endtask

    // One accepted beat; returns #1 after the accepting edge.
    task automatic issue(input opcode_t op, input reg_t s1, input reg_t s2, input reg_t d,
                         input logic ih, input logic il);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = '{opcode: op, src1: s1, src2: s2, dst: d};
        in_high         = ih;
        in_low          = il;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        exp_ret++;
    endtask

    task automatic do_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        exp_ret = 0;
        check_outs({tag, " in_reset"}, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check({tag, " ready"}, {31'd0, bus.instr_ready}, 32'd1);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        in_high         = 1'b0;
        in_low          = 1'b0;

        //        op            s1            s2       dst            ih    il    oh    ol    v     ill
        tbl[0]  = '{OP_COPY,     R_INPUT_LOW,  R_ZERO,  R_OUTPUT_LOW,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{OP_COPY,     R_INPUT_HIGH, R_ZERO,  R_OUTPUT_LOW,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{OP_COPY,     R_ZERO,       R_ZERO,  R_OUTPUT_LOW,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{OP_AND,      R_INPUT_HIGH, R_INPUT_LOW, R_REG_A,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{OP_LABEL_OF, R_REG_A,      R_ZERO,  R_OUTPUT_LOW,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{OP_COPY,     R_REG_A,      R_ZERO,  R_OUTPUT_HIGH, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{OP_NOT,      R_REG_A,      R_ZERO,  R_OUTPUT_LOW,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{OP_OR,       R_INPUT_LOW,  R_ZERO,  R_OUTPUT_LOW,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{OP_CLASSIFY, R_INPUT_LOW,  R_ZERO,  R_OUTPUT_LOW,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{OP_COPY,     R_INPUT_LOW,  R_ZERO,  R_ZERO,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{OP_COPY,     R_INPUT_LOW,  R_ZERO,  R_INPUT_HIGH,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{OP_NOT,      R_ZERO,       R_ZERO,  R_OUTPUT_LOW,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{OP_OR,       R_ZERO,       R_ZERO,  R_OUTPUT_HIGH, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{OP_ILLEGAL,  R_INPUT_LOW,  R_ZERO,  R_OUTPUT_LOW,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{OP_SKIP_NEXT, R_ZERO,      R_ZERO,  R_OUTPUT_LOW,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{OP_COPY,     R_ZERO,       R_ZERO,  R_OUTPUT_LOW,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{OP_AND,      R_INPUT_LOW,  R_INPUT_HIGH, R_REG_B,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{OP_OR,       R_REG_B,      R_INPUT_LOW, R_OUTPUT_HIGH, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{OP_AND,      R_INPUT_LOW,  R_INPUT_LOW, R_OUTPUT_LOW,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[19] = '{OP_COPY,     R_REG_C,      R_ZERO,  R_OUTPUT_LOW,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        check_outs("power_on_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", {31'd0, bus.instr_ready}, 32'd1);

        for (int i = 0; i < 20; i++) begin
            issue(tbl[i].op, tbl[i].s1, tbl[i].s2, tbl[i].d, tbl[i].ih, tbl[i].il);
            check_outs($sformatf("vec%0d", i), tbl[i].oh, tbl[i].ol, tbl[i].v, tbl[i].ill);
        end

        // viol is a single-cycle pulse and idle cycles change nothing.
        issue(OP_COPY, R_INPUT_HIGH, R_ZERO, R_OUTPUT_LOW, 1'b1, 1'b0);
        check_outs("blocked_low", 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_outs("idle_gap", 1'b1, 1'b0, 1'b0, 1'b0);

        // Low-valued skip discards the next beat but still retires it.
        do_reset("skip_low");
        issue(OP_SKIP_NEXT, R_INPUT_LOW, R_ZERO, R_OUTPUT_HIGH, 1'b0, 1'b1);
        issue(OP_COPY, R_INPUT_LOW, R_ZERO, R_OUTPUT_LOW, 1'b0, 1'b1);
        check_outs("skip_low", 1'b0, 1'b0, 1'b0, 1'b0);
        check("skip_low retired_is_2", {16'd0, retired}, 32'd2);

        // A skipped SKIP_NEXT has no effect; the following beat executes.
        do_reset("skip_skip");
        issue(OP_SKIP_NEXT, R_INPUT_LOW, R_ZERO, R_ZERO, 1'b0, 1'b1);
        issue(OP_SKIP_NEXT, R_INPUT_LOW, R_ZERO, R_ZERO, 1'b0, 1'b1);
        issue(OP_COPY, R_INPUT_LOW, R_ZERO, R_OUTPUT_LOW, 1'b0, 1'b1);
        check_outs("skip_skip", 1'b0, 1'b1, 1'b0, 1'b0);

        // High-context skip: REG_B label high either way, value depends on in_high.
        for (int h = 0; h < 2; h++) begin
            logic hb;
            hb = (h == 1);
            do_reset($sformatf("shadow_reg_h%0d", h));
            issue(OP_SKIP_NEXT, R_INPUT_HIGH, R_ZERO, R_ZERO, hb, 1'b0);
            issue(OP_NOT, R_ZERO, R_ZERO, R_REG_B, hb, 1'b0);
            check_outs($sformatf("shadow_reg_h%0d beat", h), 1'b0, 1'b0, 1'b0, 1'b0);
            issue(OP_LABEL_OF, R_REG_B, R_ZERO, R_OUTPUT_LOW, 1'b0, 1'b0);
            check_outs($sformatf("shadow_reg_h%0d label", h), 1'b0, 1'b1, 1'b0, 1'b0);
            issue(OP_COPY, R_REG_B, R_ZERO, R_OUTPUT_HIGH, 1'b0, 1'b0);
            check_outs($sformatf("shadow_reg_h%0d value", h), ~hb, 1'b1, 1'b0, 1'b0);
            issue(OP_COPY, R_REG_B, R_ZERO, R_OUTPUT_LOW, 1'b0, 1'b0);
            check_outs($sformatf("shadow_reg_h%0d to_low", h), ~hb, 1'b1, 1'b1, 1'b0);
        end

        // High-context skip targeting OUTPUT_LOW: viol either way, out_low kept.
        for (int h = 0; h < 2; h++) begin
            logic hb;
            hb = (h == 1);
            do_reset($sformatf("shadow_low_h%0d", h));
            issue(OP_COPY, R_INPUT_LOW, R_ZERO, R_OUTPUT_LOW, 1'b0, 1'b1);
            issue(OP_SKIP_NEXT, R_INPUT_HIGH, R_ZERO, R_ZERO, hb, 1'b0);
            issue(OP_COPY, R_ZERO, R_ZERO, R_OUTPUT_LOW, hb, 1'b0);
            check_outs($sformatf("shadow_low_h%0d", h), 1'b0, 1'b1, 1'b1, 1'b0);
        end

        // Reset mid-stream after a SKIP_NEXT discards the pending skip.
        do_reset("mid_reset");
        issue(OP_COPY, R_INPUT_LOW, R_ZERO, R_OUTPUT_LOW, 1'b0, 1'b1);
        issue(OP_COPY, R_INPUT_LOW, R_ZERO, R_OUTPUT_HIGH, 1'b0, 1'b1);
        issue(OP_SKIP_NEXT, R_INPUT_LOW, R_ZERO, R_ZERO, 1'b0, 1'b1);
        check_outs("mid_reset before", 1'b1, 1'b1, 1'b0, 1'b0);
        do_reset("mid_reset");
        issue(OP_COPY, R_INPUT_LOW, R_ZERO, R_OUTPUT_LOW, 1'b0, 1'b1);
        check_outs("mid_reset after", 1'b0, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
